// File: rtl/io_bus_pkg.sv
// Shared types and default timing for the Mac I/O bus initiator.
package io_bus_pkg;

  localparam int unsigned E_TOTAL_DEF = 10;
  localparam int unsigned E_HIGH_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    S2,
    S4,
    WAIT,
    VWAIT,
    S6,
    S7
  } busState_t;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for an active-low asynchronous bus input; resets negated.
module io_sync2 (
  input  logic CLK,
  input  logic nRST,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      meta <= 1'b1;
      Q    <= 1'b1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/io_bus_master.sv
// 68000-style asynchronous bus initiator with VPA/VMA synchronous cycles,
// bus-error and timeout termination, and a free-running E clock.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int unsigned E_TOTAL = E_TOTAL_DEF,
  parameter int unsigned E_HIGH  = E_HIGH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic nRST,
  input  logic IOREQ,
  input  logic IOWE,
  input  logic IOUDS,
  input  logic IOLDS,
  output logic IOACT,
  output logic IOReady,
  output logic IOBERR,
  output logic IODataLE,
  output logic nAS,
  output logic nUDS,
  output logic nLDS,
  output logic nWE,
  output logic nVMA,
  output logic E,
  input  logic nDTACK,
  input  logic nVPA,
  input  logic nBERR
);

  localparam int unsigned EW = (E_TOTAL > 1) ? $clog2(E_TOTAL) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [EW-1:0] ELAST     = EW'(E_TOTAL - 1);
  localparam logic [EW-1:0] ERISE     = EW'(E_TOTAL - E_HIGH);
  localparam logic [EW-1:0] ERISE_PRE = EW'(E_TOTAL - E_HIGH - 1);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);

  logic dtackS, vpaS, berrS;

  io_sync2 dtackSync (.CLK(CLK), .nRST(nRST), .D(nDTACK), .Q(dtackS));
  io_sync2 vpaSync   (.CLK(CLK), .nRST(nRST), .D(nVPA),   .Q(vpaS));
  io_sync2 berrSync  (.CLK(CLK), .nRST(nRST), .D(nBERR),  .Q(berrS));

  // E clock: E is registered from the next count so it tracks Ecnt exactly.
  logic [EW-1:0] ecnt, ecntN;

  always_comb begin
    ecntN = (ecnt == ELAST) ? '0 : ecnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ecnt <= '0;
      E    <= 1'b0;
    end else begin
      ecnt <= ecntN;
      E    <= (ecntN >= ERISE);
    end
  end

  busState_t     state, stateN;
  logic          weR, udsR, ldsR, errR;
  logic          weN, udsN, ldsN, errN;
  logic [TW-1:0] tcnt, tcntN;
  logic          nAsN, nUdsN, nLdsN, nWeN, nVmaN;
  logic          readyN, berrOutN, leN;

  // Every output is registered, so each branch sets the value seen in the state being entered.
  always_comb begin
    stateN   = state;
    weN      = weR;
    udsN     = udsR;
    ldsN     = ldsR;
    errN     = errR;
    tcntN    = tcnt;
    nAsN     = nAS;
    nUdsN    = nUDS;
    nLdsN    = nLDS;
    nWeN     = nWE;
    nVmaN    = nVMA;
    readyN   = 1'b0;
    berrOutN = 1'b0;
    leN      = 1'b0;

    unique case (state)
      IDLE: begin
        if (IOREQ) begin
          stateN = S2;
          weN    = IOWE;
          udsN   = IOUDS;
          ldsN   = IOLDS;
          errN   = 1'b0;
          nAsN   = 1'b0;
          nWeN   = !IOWE;
          if (!IOWE) begin
            nUdsN = !IOUDS;
            nLdsN = !IOLDS;
          end
        end
      end

      S2: begin
        stateN = S4;
        tcntN  = '0;
        if (weR) begin
          nUdsN = !udsR;
          nLdsN = !ldsR;
        end
      end

      S4: stateN = WAIT;

      WAIT: begin
        if (!berrS) begin
          stateN = S6;
          errN   = 1'b1;
        end else if (!dtackS) begin
          stateN = S6;
          leN    = !weR;
        end else if (!vpaS) begin
          stateN = VWAIT;
        end else if (tcnt == TMAX) begin
          stateN = S6;
          errN   = 1'b1;
        end else if (tcnt != '1) begin
          tcntN = tcnt + 1'b1;
        end
      end

      VWAIT: begin
        if (!berrS) begin
          stateN = S6;
          errN   = 1'b1;
        end else if ((ecnt == ELAST) && !nVMA) begin
          stateN = S6;
          leN    = !weR;
        end else if (tcnt == TMAX) begin
          stateN = S6;
          errN   = 1'b1;
        end else begin
          if (tcnt != '1) begin
            tcntN = tcnt + 1'b1;
          end
          if (ecnt == ERISE_PRE) begin
            nVmaN = 1'b0;
          end
        end
      end

      S6: begin
        stateN   = S7;
        nAsN     = 1'b1;
        nUdsN    = 1'b1;
        nLdsN    = 1'b1;
        nWeN     = 1'b1;
        nVmaN    = 1'b1;
        readyN   = 1'b1;
        berrOutN = errR;
      end

      S7: stateN = IDLE;

      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      weR      <= 1'b0;
      udsR     <= 1'b0;
      ldsR     <= 1'b0;
      errR     <= 1'b0;
      tcnt     <= '0;
      nAS      <= 1'b1;
      nUDS     <= 1'b1;
      nLDS     <= 1'b1;
      nWE      <= 1'b1;
      nVMA     <= 1'b1;
      IOACT    <= 1'b0;
      IOReady  <= 1'b0;
      IOBERR   <= 1'b0;
      IODataLE <= 1'b0;
    end else begin
      state    <= stateN;
      weR      <= weN;
      udsR     <= udsN;
      ldsR     <= ldsN;
      errR     <= errN;
      tcnt     <= tcntN;
      nAS      <= nAsN;
      nUDS     <= nUdsN;
      nLDS     <= nLdsN;
      nWE      <= nWeN;
      nVMA     <= nVmaN;
      IOACT    <= (stateN != IDLE);
      IOReady  <= readyN;
      IOBERR   <= berrOutN;
      IODataLE <= leN;
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed, table-driven bench for io_bus_master with hand-computed cycle counts.
module tb_io_bus_master;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic IOREQ = 1'b0, IOWE = 1'b0, IOUDS = 1'b0, IOLDS = 1'b0;
  logic nDTACK = 1'b1, nVPA = 1'b1, nBERR = 1'b1;
  logic IOACT, IOReady, IOBERR, IODataLE;
  logic nAS, nUDS, nLDS, nWE, nVMA, E;

  int passCnt = 0;
  int totalCnt = 0;

  localparam int K_DTACK = 0;
  localparam int K_BERR  = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;
  localparam int K_DTVPA = 4;

  typedef struct {
    string name;
    logic  we, uds, lds;
    int    kind, dly;
    int    expLat;
    int    expErr;
    int    expLe;
    int    expUdsAt, expLdsAt;
  } vec_t;

  io_bus_master #(
    .E_TOTAL(10),
    .E_HIGH (4),
    .TIMEOUT(255)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .IOREQ   (IOREQ),
    .IOWE    (IOWE),
    .IOUDS   (IOUDS),
    .IOLDS   (IOLDS),
    .IOACT   (IOACT),
    .IOReady (IOReady),
    .IOBERR  (IOBERR),
    .IODataLE(IODataLE),
    .nAS     (nAS),
    .nUDS    (nUDS),
    .nLDS    (nLDS),
    .nWE     (nWE),
    .nVMA    (nVMA),
    .E       (E),
    .nDTACK  (nDTACK),
    .nVPA    (nVPA),
    .nBERR   (nBERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic u, input logic l,
                              input int kind, input int dly, input int lat, input int err,
                              input int le, input int ua, input int la);
    vec_t v;
    v.name = n; v.we = we; v.uds = u; v.lds = l;
    v.kind = kind; v.dly = dly; v.expLat = lat; v.expErr = err;
    v.expLe = le; v.expUdsAt = ua; v.expLdsAt = la;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Edge k=0 is the edge that samples IOREQ; all indices below count from it.
  task automatic runVec(input vec_t v);
    int readyAt = -1, udsAt = -1, ldsAt = -1, leAt = -1, leCnt = 0;
    int berrSeen = 0, vmaLow = 0, nweAt0 = -1, actAt0 = -1;
    @(negedge CLK);
    IOWE = v.we; IOUDS = v.uds; IOLDS = v.lds; IOREQ = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK); #1;
      if (k == 0) begin
        IOREQ  = 1'b0;
        nweAt0 = int'(nWE);
        actAt0 = int'(IOACT);
      end
      if (!nUDS && udsAt < 0) udsAt = k;
      if (!nLDS && ldsAt < 0) ldsAt = k;
      if (!nVMA) vmaLow = 1;
      if (IODataLE) begin leCnt++; leAt = k; end
      if (IOReady) begin readyAt = k; berrSeen = int'(IOBERR); break; end
      if (k >= v.dly) begin
        if (v.kind == K_DTACK || v.kind == K_BOTH || v.kind == K_DTVPA) nDTACK = 1'b0;
        if (v.kind == K_BERR || v.kind == K_BOTH) nBERR = 1'b0;
        if (v.kind == K_DTVPA) nVPA = 1'b0;
      end
    end
    nDTACK = 1'b1; nBERR = 1'b1; nVPA = 1'b1;
    @(posedge CLK); #1;
    check({v.name, ".readyLat"}, readyAt, v.expLat);
    check({v.name, ".berr"}, berrSeen, v.expErr);
    check({v.name, ".leCount"}, leCnt, v.expLe);
    if (v.expLe != 0) check({v.name, ".leEdge"}, leAt, v.expLat - 1);
    check({v.name, ".udsFirstLow"}, udsAt, v.expUdsAt);
    check({v.name, ".ldsFirstLow"}, ldsAt, v.expLdsAt);
    check({v.name, ".nWE"}, nweAt0, v.we ? 0 : 1);
    check({v.name, ".actStart"}, actAt0, 1);
    check({v.name, ".vmaLow"}, vmaLow, 0);
    check({v.name, ".actEnd"}, int'(IOACT), 0);
    idle(3);
  endtask

  vec_t vecs[8];

  initial begin
    logic [19:0] eGot, eExp;
    int vmaAt, eAtVma, ePrevVma, leAt, eAtLe, ePrevLe, readyAt, vmaAtRdy, asAtRdy, berrAtRdy;
    int prevE, readyCnt, actCnt, nasFalls, prevNas, asLowBefore;

    //               name            we    uds   lds   kind     dly lat  err le ua  la
    vecs[0] = mk("rd_dtack",      1'b0, 1'b1, 1'b1, K_DTACK, 0,  4,   0, 1,  0,  0);
    vecs[1] = mk("wr_lds",        1'b1, 1'b0, 1'b1, K_DTACK, 4,  8,   0, 0, -1,  1);
    vecs[2] = mk("wr_uds",        1'b1, 1'b1, 1'b0, K_DTACK, 1,  5,   0, 0,  1, -1);
    vecs[3] = mk("rd_nods",       1'b0, 1'b0, 1'b0, K_DTACK, 2,  6,   0, 1, -1, -1);
    vecs[4] = mk("rd_berr_dtack", 1'b0, 1'b1, 1'b1, K_BOTH,  2,  6,   1, 0,  0,  0);
    vecs[5] = mk("rd_dtack_vpa",  1'b0, 1'b1, 1'b1, K_DTVPA, 0,  4,   0, 1,  0,  0);
    vecs[6] = mk("wr_berr",       1'b1, 1'b1, 1'b1, K_BERR,  0,  4,   1, 0,  1,  1);
    vecs[7] = mk("rd_timeout",    1'b0, 1'b0, 1'b1, K_NONE,  0,  259, 1, 0, -1,  0);

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("resetState", int'({nAS, nUDS, nLDS, nWE, nVMA, IOACT, IOReady, IOBERR, IODataLE, E}),
          int'(10'b11111_00000));
    nRST = 1'b1;

    // E clock: low for counts 0..5, high for 6..9
    for (int j = 1; j <= 20; j++) begin
      @(posedge CLK); #1;
      eGot[j-1] = E;
      eExp[j-1] = ((j % 10) >= 6);
    end
    check("eClockPattern", int'(eGot), int'(eExp));

    for (int i = 0; i < 8; i++) runVec(vecs[i]);

    // VPA read: reset aligns Ecnt so that Ecnt becomes 2 on the request edge
    @(negedge CLK); nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IOWE = 1'b0; IOUDS = 1'b1; IOLDS = 1'b1; IOREQ = 1'b1; nVPA = 1'b0;
    vmaAt = -1; eAtVma = -1; ePrevVma = -1; leAt = -1; eAtLe = -1; ePrevLe = -1;
    readyAt = -1; vmaAtRdy = -1; asAtRdy = -1; berrAtRdy = -1; prevE = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge CLK); #1;
      if (k == 0) IOREQ = 1'b0;
      if (!nVMA && vmaAt < 0) begin vmaAt = k; eAtVma = int'(E); ePrevVma = prevE; end
      if (IODataLE && leAt < 0) begin leAt = k; eAtLe = int'(E); ePrevLe = prevE; end
      if (IOReady) begin
        readyAt = k; vmaAtRdy = int'(nVMA); asAtRdy = int'(nAS); berrAtRdy = int'(IOBERR);
        break;
      end
      prevE = int'(E);
    end
    nVPA = 1'b1;
    check("vpa.vmaEdge", vmaAt, 4);
    check("vpa.eAtVma", eAtVma, 1);
    check("vpa.ePrevVma", ePrevVma, 0);
    check("vpa.leEdge", leAt, 8);
    check("vpa.eAtLe", eAtLe, 0);
    check("vpa.ePrevLe", ePrevLe, 1);
    check("vpa.readyEdge", readyAt, 9);
    check("vpa.nVmaAtReady", vmaAtRdy, 1);
    check("vpa.nAsAtReady", asAtRdy, 1);
    check("vpa.berr", berrAtRdy, 0);
    idle(3);

    // Reset during WAIT abandons the cycle
    @(negedge CLK);
    IOWE = 1'b0; IOUDS = 1'b1; IOLDS = 1'b1; IOREQ = 1'b1;
    asLowBefore = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      if (k == 0) IOREQ = 1'b0;
      if (k == 3) asLowBefore = int'(!nAS);
    end
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    check("rst.asActiveBefore", asLowBefore, 1);
    check("rst.strobes", int'({nAS, nUDS, nLDS, nWE, nVMA}), int'(5'b11111));
    check("rst.flags", int'({IOACT, IOReady, IOBERR, IODataLE}), 0);
    readyCnt = 0; actCnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      if (IOReady) readyCnt++;
      if (IOACT) actCnt++;
    end
    check("rst.noReady", readyCnt, 0);
    check("rst.noAct", actCnt, 0);

    // IOREQ pulsed during S4 is ignored
    @(negedge CLK);
    IOWE = 1'b0; IOUDS = 1'b1; IOLDS = 1'b0; IOREQ = 1'b1; nDTACK = 1'b0;
    readyCnt = 0; nasFalls = 0; prevNas = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      if (k == 0) IOREQ = 1'b0;
      if (k == 1) IOREQ = 1'b1;
      if (k == 2) IOREQ = 1'b0;
      if (IOReady) readyCnt++;
      if (prevNas == 1 && nAS == 1'b0) nasFalls++;
      prevNas = int'(nAS);
    end
    nDTACK = 1'b1;
    check("s4req.readyCount", readyCnt, 1);
    check("s4req.asFalls", nasFalls, 1);
    check("s4req.idleAfter", int'(IOACT), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
